aes_round_sequencer: RTL
========================

Name: aes_round_sequencer

Overview:
Iterative AES-128 encryption controller. Owns the 128-bit state and round-key registers and sequences the team's single-cycle round datapath (sub_bytes → shift_rows → mix_columns → add_round_key, plus the key-expansion step) over the rounds. Exposes valid/ready handshakes on the plaintext input and the ciphertext output. Sits between the bus-side block wrapper and the combinational round logic.

Parameters:
NR, 10, number of rounds; only 10 (AES-128) is supported.
W, 128, block and key width in bits; byte 0 is at [W-1:W-8], column-major state order.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush_i  input  1  synchronous abort; forces IDLE
in_valid_i  input  1  plaintext/key offered
in_ready_o  output  1  sequencer can accept
pt_i  input  W  plaintext
key_i  input  W  cipher key
out_valid_o  output  1  ciphertext valid
out_ready_i  input  1  consumer accepts ciphertext
ct_o  output  W  ciphertext; equals the state register
busy_o  output  1  high in ROUND
round_o  output  4  current round number
rd_state_o  output  W  state to round datapath (state register)
rd_key_o  output  W  previous round key to key expansion (key register)
rd_rcon_o  output  8  round constant for the current round
rd_final_o  output  1  high when round_o == NR (skip mix_columns)
rd_state_i  input  W  round datapath result
rd_key_i  input  W  expanded round key (also used by rd_state_i)

Behaviour:
- Reset (async, rst_n low): FSM=IDLE, round=0, state_reg=0, key_reg=0, out_valid_o=0, busy_o=0. in_ready_o=1 once reset is released.
- FSM states: IDLE, ROUND, DONE.
- in_ready_o is combinational: IDLE | (DONE & out_ready_i). Accept = in_valid_i & in_ready_o.
- On accept: state_reg <= pt_i ^ key_i (initial AddRoundKey), key_reg <= key_i, round <= 1, go to ROUND.
- ROUND, every cycle: state_reg <= rd_state_i, key_reg <= rd_key_i.
  - If round < NR: round <= round+1.
  - If round == NR: go to DONE.
- rd_rcon_o by round 1..10: 01,02,04,08,10,20,40,80,1b,36. Value is 00 in IDLE and DONE.
- rd_final_o = (FSM==ROUND) & (round==NR).
- DONE: out_valid_o=1. ct_o and round_o (=NR) are held stable until out_ready_i.
  - out_ready_i without accept: go to IDLE, round <= 0.
  - out_ready_i with simultaneous accept: load the new block and go directly to ROUND (back-to-back, zero bubble).
- Latency: accept in cycle T → out_valid_o high in cycle T+NR+1 (T+11). Throughput: one block per 11 cycles with back-to-back accept.
- in_valid_i during ROUND is ignored (in_ready_o=0). pt_i/key_i are sampled only on accept.
- flush_i (priority over all except reset): next state IDLE, round=0, out_valid_o=0, state_reg and key_reg cleared. Any in-flight or pending result is discarded. in_ready_o=0 in the flush cycle.
- Async reset mid-ROUND or in DONE: immediate return to the reset values. No partial output is produced.
- out_valid_o must not drop without out_ready_i, except on flush or reset.

Test Plan:
1. FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → ct_o 3925841d02dc09fbdc118597196a0b32, out_valid_o exactly 11 cycles after accept.
2. FIPS-197 App. C.1: key 000102…0f, pt 00112233445566778899aabbccddeeff → ct_o 69c4e0d86a7b0430d8cdb78070b4c55a. Check rd_rcon_o sequence 01…36 and rd_final_o high only in round 10.
3. Backpressure: hold out_ready_i=0 for 20 cycles in DONE → ct_o stable, out_valid_o held, in_ready_o=0, in_valid_i ignored.
4. Back-to-back: vector 1 then vector 2 with out_ready_i=1 and in_valid_i=1 in the DONE cycle → second accept in the same cycle, second ct 11 cycles later. Both ciphertexts correct.
5. flush_i asserted at round 5 → next cycle IDLE, round_o=0, no out_valid_o. A following encryption of vector 1 returns the correct ct.
6. rst_n pulsed low mid-round 7 and in DONE → all outputs at reset values asynchronously. Normal operation resumes after release.

Source files
------------

// File: rtl/aes_round_sequencer.sv
// -----------------------------------------------------------------------------
// aes_round_sequencer
//
// Iterative AES-128 encryption controller. Holds the 128-bit cipher state and
// the current round key, and walks an external single-cycle round datapath
// (sub_bytes, shift_rows, mix_columns, add_round_key plus one key-expansion
// step) through the ten rounds. Plaintext enters and ciphertext leaves over
// valid/ready handshakes. A new block may be accepted in the same cycle the
// previous ciphertext is consumed, so blocks can stream one per NR+1 cycles.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   flush_i              synchronous abort, returns to IDLE and clears data
//   in_valid_i/in_ready_o  plaintext/key handshake
//   pt_i, key_i          plaintext and cipher key, sampled on accept only
//   out_valid_o/out_ready_i  ciphertext handshake
//   ct_o                 ciphertext (the state register)
//   busy_o               high while rounds are in progress
//   round_o              current round number (0 idle, 1..NR)
//   rd_state_o, rd_key_o  state and previous round key to the round datapath
//   rd_rcon_o            round constant for the current round (0 outside ROUND)
//   rd_final_o           last round: datapath skips mix_columns
//   rd_state_i, rd_key_i  datapath results: next state and next round key
// Byte 0 of every W-bit bus sits at [W-1:W-8]; the state is column-major.
// -----------------------------------------------------------------------------
module aes_round_sequencer #(
    parameter int NR = 10,
    parameter int W  = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] pt_i,
    input  logic [W-1:0] key_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] ct_o,
    output logic         busy_o,
    output logic [3:0]   round_o,
    output logic [W-1:0] rd_state_o,
    output logic [W-1:0] rd_key_o,
    output logic [7:0]   rd_rcon_o,
    output logic         rd_final_o,
    input  logic [W-1:0] rd_state_i,
    input  logic [W-1:0] rd_key_i
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_e;

    fsm_e         fsm_q,   fsm_d;
    logic [3:0]   round_q, round_d;
    logic [W-1:0] state_q, state_d;
    logic [W-1:0] key_q,   key_d;
    logic         accept;

    // AES-128 round constants: successive doublings in GF(2^8), indexed by round.
    function automatic logic [7:0] rcon_of(input logic [3:0] round);
        case (round)
            4'd1:    rcon_of = 8'h01;
            4'd2:    rcon_of = 8'h02;
            4'd3:    rcon_of = 8'h04;
            4'd4:    rcon_of = 8'h08;
            4'd5:    rcon_of = 8'h10;
            4'd6:    rcon_of = 8'h20;
            4'd7:    rcon_of = 8'h40;
            4'd8:    rcon_of = 8'h80;
            4'd9:    rcon_of = 8'h1b;
            4'd10:   rcon_of = 8'h36;
            default: rcon_of = 8'h00;
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // State register (FSM plus the data it owns)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            round_q <= 4'd0;
            state_q <= '0;
            key_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the values
            // computed before this edge, independent of statement order.
            fsm_q   <= fsm_d;
            round_q <= round_d;
            state_q <= state_d;
            key_q   <= key_d;
        end
    end

    // ------------------------------------------------------------------------
    // Output logic (depends on the current state; in_ready also looks at
    // out_ready_i so a DONE block can hand over to a new one with no bubble)
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;
        rd_rcon_o   = 8'h00;
        rd_final_o  = 1'b0;
        case (fsm_q)
            IDLE: begin
                in_ready_o = !flush_i;
            end
            ROUND: begin
                busy_o     = 1'b1;
                rd_rcon_o  = rcon_of(round_q);
                rd_final_o = (round_q == LAST_ROUND);
            end
            DONE: begin
                out_valid_o = 1'b1;
                in_ready_o  = out_ready_i && !flush_i;
            end
            default: ;
        endcase
    end

    assign accept = in_valid_i && in_ready_o;

    // ------------------------------------------------------------------------
    // Next-state logic: FSM and round counter
    // ------------------------------------------------------------------------
    always_comb begin
        fsm_d   = fsm_q;
        round_d = round_q;
        if (flush_i) begin
            fsm_d   = IDLE;
            round_d = 4'd0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (accept) begin
                        fsm_d   = ROUND;
                        round_d = 4'd1;
                    end
                end
                ROUND: begin
                    if (round_q == LAST_ROUND) begin
                        fsm_d = DONE;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end
                DONE: begin
                    // Consumer taking the result while a new block is offered
                    // restarts immediately; otherwise fall back to IDLE.
                    if (accept) begin
                        fsm_d   = ROUND;
                        round_d = 4'd1;
                    end else if (out_ready_i) begin
                        fsm_d   = IDLE;
                        round_d = 4'd0;
                    end
                end
                default: begin
                    fsm_d   = IDLE;
                    round_d = 4'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic: state and round-key registers
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        if (flush_i) begin
            state_d = '0;
            key_d   = '0;
        end else if (accept) begin
            // Initial AddRoundKey happens here; round 1 then starts from it.
            state_d = pt_i ^ key_i;
            key_d   = key_i;
        end else if (fsm_q == ROUND) begin
            state_d = rd_state_i;
            key_d   = rd_key_i;
        end
    end

    assign ct_o       = state_q;
    assign round_o    = round_q;
    assign rd_state_o = state_q;
    assign rd_key_o   = key_q;

endmodule
